// File: rtl/fetch_req_arbiter_pkg.sv
// fetch_req_arbiter_pkg: shared widths, FSM encoding and requester ids for the fetch request arbiter
package fetch_req_arbiter_pkg;
  localparam int DEF_PC_WIDTH     = 32;
  localparam int DEF_OFFSET_WIDTH = 4;
  localparam int DEF_INDEX_WIDTH  = 8;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_SLEEP = 2'd2} arb_state_e;
  typedef enum logic [1:0] {RQ_REDIRECT = 2'd0, RQ_DEMAND = 2'd1, RQ_PF = 2'd2} req_id_e;
endpackage

// File: rtl/fetch_req_tag_fifo.sv
// fetch_req_tag_fifo: ordered in-flight request FIFO with per-entry stale bits and live-entry count
module fetch_req_tag_fifo
  import fetch_req_arbiter_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          mark_all_stale_i,
  input  logic [DW-1:0] push_data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic [AW:0]   live_count_o,
  output logic [DW-1:0] head_o,
  output logic          head_stale_o
);
  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] stale_q, stale_d;
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  assign full_o       = cnt_q == (AW+1)'(DEPTH);
  assign empty_o      = cnt_q == '0;
  assign count_o      = cnt_q;
  assign head_o       = mem_q[rd_q];
  assign head_stale_o = stale_q[rd_q];
  // marking wins over a same-cycle push so an entry accepted alongside a redirect is already stale
  always_comb begin
    stale_d      = stale_q;
    live_count_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stale_d[i] = mark_all_stale_i | (stale_q[i] & ~(push_i && wr_q == AW'(i)));
      if ({1'b0, AW'(AW'(i) - rd_q)} < cnt_q && !stale_q[i]) live_count_o = live_count_o + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      stale_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(push_i);
      rd_q    <= rd_q + AW'(pop_i);
      cnt_q   <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
      stale_q <= stale_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end
endmodule

// File: rtl/fetch_req_arbiter.sv
// fetch_req_arbiter: redirect > demand > prefetch scheduler onto the L1I port with stale-response filtering.
// Prefetch requester is enabled by defining FETCH_ARB_PREFETCH_EN.
module fetch_req_arbiter
  import fetch_req_arbiter_pkg::*;
#(
  parameter int PC_WIDTH          = DEF_PC_WIDTH,
  parameter int L1I_OFFSET_WIDTH  = DEF_OFFSET_WIDTH,
  parameter int L1I_INDEX_WIDTH   = DEF_INDEX_WIDTH,
  parameter int L1I_TAG_WIDTH     = PC_WIDTH - L1I_OFFSET_WIDTH - L1I_INDEX_WIDTH,
  parameter int FETCH_WIDTH       = 128,
  parameter int OUTSTANDING_DEPTH = 4,
  parameter int CREDIT_WIDTH      = 3,
  localparam int CNT_W            = $clog2(OUTSTANDING_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        redirect_vld_i,
  input  logic [PC_WIDTH-1:0]         redirect_pc_i,
  input  logic                        demand_vld_i,
  input  logic [PC_WIDTH-1:0]         demand_pc_i,
  input  logic                        pf_vld_i,
  input  logic [PC_WIDTH-1:0]         pf_pc_i,
  output logic                        demand_ack_o,
  output logic                        pf_ack_o,
  input  logic                        wfi_i,
  input  logic [CREDIT_WIDTH-1:0]     buf_free_lines_i,
  output logic                        fetch_l1i_if_req_vld_o,
  input  logic                        fetch_l1i_if_req_rdy_i,
  output logic [L1I_INDEX_WIDTH-1:0]  fetch_l1i_if_req_index_o,
  output logic [L1I_OFFSET_WIDTH-1:0] fetch_l1i_if_req_offset_o,
  output logic [L1I_TAG_WIDTH-1:0]    fetch_l1i_if_req_vtag_o,
  input  logic                        l1i_fetch_if_resp_vld_i,
  input  logic [FETCH_WIDTH-1:0]      l1i_fetch_if_resp_data_i,
  output logic                        ib_refill_vld_o,
  output logic [FETCH_WIDTH-1:0]      ib_refill_data_o,
  output logic [PC_WIDTH-1:0]         ib_refill_pc_o,
  output logic                        ib_refill_demand_o,
  output logic [CNT_W-1:0]            outstanding_o
);
`ifdef FETCH_ARB_PREFETCH_EN
  localparam int DW = PC_WIDTH + 1;
`else
  localparam int DW = PC_WIDTH;
`endif
  arb_state_e          state_q, state_d;
  req_id_e             win;
  logic [PC_WIDTH-1:0] hold_pc_q, hold_pc_d, win_pc;
  logic [PC_WIDTH-1:0] refill_pc_q;
  logic [FETCH_WIDTH-1:0] refill_data_q;
  logic                refill_vld_q;
  logic                fifo_full, fifo_empty, head_stale;
  logic [CNT_W-1:0]    live_cnt;
  logic [DW-1:0]       head, push_data;
  logic                credit_ok, req_vld, accept, slot_free, issue_ok, pf_req, capture, pop, fwd;
  assign credit_ok = 32'(live_cnt) < 32'(buf_free_lines_i);
  assign req_vld   = state_q == ST_REQ && !fifo_full && credit_ok;
  assign accept    = req_vld && fetch_l1i_if_req_rdy_i;
  assign slot_free = state_q == ST_IDLE || accept;
  assign issue_ok  = slot_free && !wfi_i && !fifo_full && credit_ok;
  assign win       = redirect_vld_i ? RQ_REDIRECT : demand_vld_i ? RQ_DEMAND : RQ_PF;
  assign capture   = redirect_vld_i || (issue_ok && (demand_vld_i || pf_req));
  assign demand_ack_o = capture && win == RQ_DEMAND;
  assign pop       = l1i_fetch_if_resp_vld_i && !fifo_empty;
  assign fwd       = pop && !head_stale && !redirect_vld_i;
`ifdef FETCH_ARB_PREFETCH_EN
  logic hold_dem_q, refill_dem_q;
  assign pf_req    = pf_vld_i;
  assign pf_ack_o  = capture && win == RQ_PF;
  assign win_pc    = win == RQ_REDIRECT ? redirect_pc_i : win == RQ_DEMAND ? demand_pc_i : pf_pc_i;
  assign push_data = {hold_dem_q, hold_pc_q};
  assign ib_refill_demand_o = refill_dem_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_dem_q   <= 1'b0;
      refill_dem_q <= 1'b0;
    end else begin
      if (capture) hold_dem_q <= win != RQ_PF;
      if (fwd) refill_dem_q <= head[DW-1];
    end
  end
`else
  logic unused_pf;
  assign unused_pf = ^{pf_vld_i, pf_pc_i};
  assign pf_req    = 1'b0;
  assign pf_ack_o  = 1'b0;
  assign win_pc    = redirect_vld_i ? redirect_pc_i : demand_pc_i;
  assign push_data = hold_pc_q;
  assign ib_refill_demand_o = 1'b1;
`endif
  assign fetch_l1i_if_req_vld_o    = req_vld;
  assign fetch_l1i_if_req_offset_o = hold_pc_q[L1I_OFFSET_WIDTH-1:0];
  assign fetch_l1i_if_req_index_o  = hold_pc_q[L1I_OFFSET_WIDTH +: L1I_INDEX_WIDTH];
  assign fetch_l1i_if_req_vtag_o   = hold_pc_q[PC_WIDTH-1 -: L1I_TAG_WIDTH];
  assign ib_refill_vld_o  = refill_vld_q;
  assign ib_refill_data_o = refill_data_q;
  assign ib_refill_pc_o   = refill_pc_q;
  // a redirect always lands in the holding register, discarding any unaccepted request
  always_comb begin
    state_d   = state_q;
    hold_pc_d = hold_pc_q;
    if (capture) begin
      state_d   = wfi_i ? ST_SLEEP : ST_REQ;
      hold_pc_d = win_pc;
    end else if (accept) state_d = ST_IDLE;
    else if (state_q == ST_REQ && wfi_i) state_d = ST_SLEEP;
    else if (state_q == ST_SLEEP && !wfi_i) state_d = ST_REQ;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hold_pc_q     <= '0;
      refill_vld_q  <= 1'b0;
      refill_data_q <= '0;
      refill_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_pc_q    <= hold_pc_d;
      refill_vld_q <= fwd;
      if (fwd) begin
        refill_data_q <= l1i_fetch_if_resp_data_i;
        refill_pc_q   <= head[PC_WIDTH-1:0];
      end
    end
  end
  fetch_req_tag_fifo #(.DW(DW), .DEPTH(OUTSTANDING_DEPTH)) u_fifo (
    .clk              (clk),
    .rst              (rst),
    .push_i           (accept),
    .pop_i            (pop),
    .mark_all_stale_i (redirect_vld_i),
    .push_data_i      (push_data),
    .full_o           (fifo_full),
    .empty_o          (fifo_empty),
    .count_o          (outstanding_o),
    .live_count_o     (live_cnt),
    .head_o           (head),
    .head_stale_o     (head_stale)
  );
  resp_needs_request: assert property (@(posedge clk) disable iff (rst)
    !(l1i_fetch_if_resp_vld_i && fifo_empty)) else $error("l1i response with no request in flight");
endmodule

// File: tb/tb_fetch_req_arbiter.sv
// tb_fetch_req_arbiter: directed stimulus with a refill scoreboard for fetch_req_arbiter
module tb_fetch_req_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic         rst, redirect_vld, demand_vld, pf_vld, demand_ack, pf_ack, wfi;
  logic [31:0]  redirect_pc, demand_pc, pf_pc, refill_pc;
  logic [2:0]   buf_free, outstanding;
  logic         req_vld, req_rdy, resp_vld, refill_vld, refill_dem;
  logic [7:0]   req_index;
  logic [3:0]   req_offset;
  logic [19:0]  req_vtag;
  logic [127:0] resp_data, refill_data;
  fetch_req_arbiter dut (
    .clk(clk), .rst(rst),
    .redirect_vld_i(redirect_vld), .redirect_pc_i(redirect_pc),
    .demand_vld_i(demand_vld), .demand_pc_i(demand_pc),
    .pf_vld_i(pf_vld), .pf_pc_i(pf_pc),
    .demand_ack_o(demand_ack), .pf_ack_o(pf_ack),
    .wfi_i(wfi), .buf_free_lines_i(buf_free),
    .fetch_l1i_if_req_vld_o(req_vld), .fetch_l1i_if_req_rdy_i(req_rdy),
    .fetch_l1i_if_req_index_o(req_index), .fetch_l1i_if_req_offset_o(req_offset),
    .fetch_l1i_if_req_vtag_o(req_vtag),
    .l1i_fetch_if_resp_vld_i(resp_vld), .l1i_fetch_if_resp_data_i(resp_data),
    .ib_refill_vld_o(refill_vld), .ib_refill_data_o(refill_data),
    .ib_refill_pc_o(refill_pc), .ib_refill_demand_o(refill_dem),
    .outstanding_o(outstanding)
  );
  typedef struct {logic [31:0] pc; logic [127:0] data; logic dem;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  function automatic logic [127:0] line_of(input logic [31:0] pc);
    return {pc, ~pc, pc ^ 32'hA5A5_A5A5, pc + 32'h1234_5678};
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    redirect_vld = 1'b0;
    resp_vld     = 1'b0;
  endtask
  task automatic resp(input logic [31:0] pc, input logic live, input logic dem);
    resp_vld  = 1'b1;
    resp_data = line_of(pc);
    if (live) sb.push_back('{pc, line_of(pc), dem});
  endtask
  always @(negedge clk) begin
    if (!rst && refill_vld) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL refill_unexpected: got pc %0h expected no refill", refill_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("refill_pc", refill_pc, mon_e.pc);
        chk("refill_data", refill_data, mon_e.data);
        chk("refill_demand", refill_dem, mon_e.dem);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; redirect_vld = 0; redirect_pc = 0; demand_vld = 0; demand_pc = 0;
    pf_vld = 0; pf_pc = 0; wfi = 0; buf_free = 3'd7; req_rdy = 1; resp_vld = 0; resp_data = 0;
    #3;
    chk("rst_req_vld", req_vld, 0);
    chk("rst_refill_vld", refill_vld, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_demand_ack", demand_ack, 0);
    chk("rst_index", req_index, 0);
    @(posedge clk); #1 rst = 1'b0;
    // single demand request
    tick(); demand_vld = 1; demand_pc = 32'h1000;
    #1 chk("s1_ack", demand_ack, 1); chk("s1_vld_early", req_vld, 0);
    tick(); demand_vld = 0;
    #1 chk("s1_vld", req_vld, 1); chk("s1_index", req_index, 8'h00);
    chk("s1_vtag", req_vtag, 20'h1); chk("s1_offset", req_offset, 0);
    tick(); #1 chk("s1_outstanding", outstanding, 1); chk("s1_vld_done", req_vld, 0);
    tick(); resp(32'h1000, 1, 1);
    tick(); #1 chk("s1_refill_vld", refill_vld, 1); chk("s1_drained", outstanding, 0);
    // demand and prefetch together
    tick(); demand_vld = 1; demand_pc = 32'h1000; pf_vld = 1; pf_pc = 32'h1010;
    #1 chk("s2_demand_ack", demand_ack, 1); chk("s2_pf_ack", pf_ack, 0);
    tick(); demand_vld = 0;
`ifdef FETCH_ARB_PREFETCH_EN
    #1 chk("s2_pf_ack_next", pf_ack, 1);
    tick(); pf_vld = 0;
    #1 chk("s2_pf_vld", req_vld, 1); chk("s2_pf_index", req_index, 8'h01);
    tick(); resp(32'h1000, 1, 1);
    tick(); resp(32'h1010, 1, 0);
`else
    #1 chk("s2_pf_ignored", pf_ack, 0);
    tick(); pf_vld = 0;
    #1 chk("s2_no_pf_issue", req_vld, 0);
    tick(); resp(32'h1000, 1, 1);
`endif
    tick(); tick(); #1 chk("s2_drained", outstanding, 0);
    // three requests then a redirect before any response
    tick(); demand_vld = 1; demand_pc = 32'h3000;
    tick(); demand_pc = 32'h3010;
    tick(); demand_pc = 32'h3020;
    tick(); demand_vld = 0; redirect_vld = 1; redirect_pc = 32'h2000;
    #1 chk("s3_redirect_no_dack", demand_ack, 0);
    tick(); #1 chk("s3_redir_vld", req_vld, 1); chk("s3_redir_vtag", req_vtag, 20'h2);
    chk("s3_outstanding3", outstanding, 3);
    tick(); #1 chk("s3_outstanding4", outstanding, 4); resp(32'h3000, 0, 1);
    tick(); #1 chk("s3_drop0", refill_vld, 0); resp(32'h3010, 0, 1);
    tick(); #1 chk("s3_drop1", refill_vld, 0); resp(32'h3020, 0, 1);
    tick(); #1 chk("s3_drop2", refill_vld, 0); resp(32'h2000, 1, 1);
    tick(); #1 chk("s3_live_refill", refill_vld, 1); chk("s3_outstanding0", outstanding, 0);
    // redirect together with a response and an accept
    tick(); demand_vld = 1; demand_pc = 32'h4000;
    tick(); demand_pc = 32'h4010;
    tick(); demand_vld = 0; redirect_vld = 1; redirect_pc = 32'h5000; resp(32'h4000, 0, 1);
    tick(); #1 chk("s4_vtag", req_vtag, 20'h5); chk("s4_outstanding", outstanding, 1);
    chk("s4_resp_dropped", refill_vld, 0);
    tick(); resp(32'h4010, 0, 1); #1 chk("s4_outstanding2", outstanding, 2);
    tick(); resp(32'h5000, 1, 1); #1 chk("s4_accept_dropped", refill_vld, 0);
    tick(); tick(); #1 chk("s4_drained", outstanding, 0);
    // single buffer credit
    buf_free = 3'd1;
    tick(); demand_vld = 1; demand_pc = 32'h6000; #1 chk("s5_ack0", demand_ack, 1);
    tick(); demand_vld = 0;
    tick(); demand_vld = 1; demand_pc = 32'h6010; #1 chk("s5_no_credit", demand_ack, 0);
    tick(); resp(32'h6000, 1, 1); #1 chk("s5_still_no_credit", demand_ack, 0);
    tick(); #1 chk("s5_ack_after_pop", demand_ack, 1);
    tick(); demand_vld = 0; #1 chk("s5_vld", req_vld, 1); chk("s5_index", req_index, 8'h01);
    tick(); resp(32'h6010, 1, 1);
    tick(); buf_free = 3'd7;
    // fill every outstanding slot
    tick(); demand_vld = 1; demand_pc = 32'h7000;
    tick(); demand_pc = 32'h7010;
    tick(); demand_pc = 32'h7020;
    tick(); demand_pc = 32'h7030;
    tick(); demand_pc = 32'h7040; #1 chk("s6_ack_last", demand_ack, 1);
    tick(); demand_vld = 0; #1 chk("s6_full_vld", req_vld, 0); chk("s6_full_cnt", outstanding, 4);
    tick(); #1 chk("s6_full_vld2", req_vld, 0); resp(32'h7000, 1, 1);
    tick(); #1 chk("s6_vld_resume", req_vld, 1); resp(32'h7010, 1, 1);
    tick(); resp(32'h7020, 1, 1);
    tick(); resp(32'h7030, 1, 1);
    tick(); resp(32'h7040, 1, 1);
    tick(); #1 chk("s6_drained", outstanding, 0);
    // wfi while a request is held and a response is pending
    tick(); demand_vld = 1; demand_pc = 32'h8000;
    tick(); demand_pc = 32'h8040;
    tick(); demand_vld = 0; req_rdy = 0; wfi = 1;
    #1 chk("s7_vld_held", req_vld, 1); chk("s7_index", req_index, 8'h04);
    tick(); resp(32'h8000, 1, 1); #1 chk("s7_sleep_vld", req_vld, 0);
    tick(); #1 chk("s7_sleep_vld2", req_vld, 0); chk("s7_refill_in_wfi", refill_vld, 1);
    tick(); wfi = 0; #1 chk("s7_wake_vld", req_vld, 0);
    tick(); req_rdy = 1; #1 chk("s7_resume_vld", req_vld, 1); chk("s7_resume_index", req_index, 8'h04);
    tick(); resp(32'h8040, 1, 1);
    tick(); #1 chk("s7_drained", outstanding, 0);
    // reset while a request is in flight
    tick(); demand_vld = 1; demand_pc = 32'h9000;
    tick(); demand_vld = 0;
    tick(); #1 chk("s8_inflight", outstanding, 1);
    rst = 1'b1;
    #1 chk("s8_rst_cnt", outstanding, 0); chk("s8_rst_vld", req_vld, 0);
    tick(); rst = 1'b0;
    tick(); #1 chk("s8_post_cnt", outstanding, 0); chk("s8_post_refill", refill_vld, 0);
    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
